// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_pkg
// Brief    : Frame width, timeout default and rx FSM encodings shared by the
//            LED serial link transmitter and receiver.
// Revision : 1.0 - initial release
// ============================================================================
package serial_pkg;

    localparam int SERIAL_DATA_W          = 8;
    localparam int SERIAL_TIMEOUT_DEFAULT = 1024;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t RX_IDLE  = 2'd0;
    localparam rx_state_t RX_SHIFT = 2'd1;
    localparam rx_state_t RX_PUSH  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/serial_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx_if
// Brief    : Link inputs and CPU-side read port of the serial receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_rx_if
    import serial_pkg::*;
#(
    parameter int DATA_W = SERIAL_DATA_W
);
    logic              sclk;
    logic              sdata;
    logic              rd_en;
    logic              err_clr;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic              overrun;
    logic              frame_err;

    modport master (
        output sclk, sdata, rd_en, err_clr,
        input  rd_data, empty, full, overrun, frame_err
    );

    modport slave (
        input  sclk, sdata, rd_en, err_clr,
        output rd_data, empty, full, overrun, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : First-word-fall-through FIFO with sticky overrun on a dropped push.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo
    import serial_pkg::*;
#(
    parameter int DATA_W = SERIAL_DATA_W,
    parameter int DEPTH  = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_wr_en,
    input  wire logic [DATA_W-1:0] i_wr_data,
    input  wire logic              i_rd_en,
    input  wire logic              i_err_clr,
    output logic      [DATA_W-1:0] o_rd_data,
    output logic                   o_empty,
    output logic                   o_full,
    output logic                   o_overrun
);
    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;

    logic [DATA_W-1:0]   r_mem_q    [DEPTH];
    logic [DATA_W-1:0]   w_mem_d    [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_ADDR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0]  r_count_q,  w_count_d;
    logic                r_overrun_q, w_overrun_d;
    logic                w_push, w_pop, w_drop;

    assign o_empty   = (r_count_q == '0);
    assign o_full    = (r_count_q == c_CNT_W'(DEPTH));
    assign o_rd_data = r_mem_q[r_rd_ptr_q];
    assign o_overrun = r_overrun_q;

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_pop  = i_rd_en & ~o_empty;
    assign w_push = i_wr_en & (~o_full | w_pop);
    assign w_drop = i_wr_en & o_full & ~w_pop;

    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_push) begin
            w_mem_d[r_wr_ptr_q] = i_wr_data;
            w_wr_ptr_d          = r_wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
        if (w_drop) begin
            w_overrun_d = 1'b1;
        end else if (i_err_clr) begin
            w_overrun_d = 1'b0;
        end else begin
            w_overrun_d = r_overrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
            r_wr_ptr_q  <= '0;
            r_rd_ptr_q  <= '0;
            r_count_q   <= '0;
            r_overrun_q <= 1'b0;
        end else begin
            r_mem_q     <= w_mem_d;
            r_wr_ptr_q  <= w_wr_ptr_d;
            r_rd_ptr_q  <= w_rd_ptr_d;
            r_count_q   <= w_count_d;
            r_overrun_q <= w_overrun_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx
// Brief    : Oversampling receiver for the sclk/sdata LED link, MSB-first
//            frames buffered in a FWFT FIFO with overrun/frame-error flags.
// Revision : 1.0 - initial release
// ============================================================================
module serial_rx
    import serial_pkg::*;
#(
    parameter int DATA_W      = SERIAL_DATA_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = SERIAL_TIMEOUT_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic   clki,
    input  wire logic   rst,
    serial_rx_if.slave  bus
);
    localparam int c_CNT_W = $clog2(DATA_W + 1);
    localparam int c_TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_W - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] r_sclk_sync_q,  w_sclk_sync_d;
    logic [SYNC_STAGES-1:0] r_sdata_sync_q, w_sdata_sync_d;
    logic                   r_sclk_prev_q;
    rx_state_t              r_state_q, w_state_d;
    logic [DATA_W-1:0]      r_shift_q, w_shift_d;
    logic [c_CNT_W-1:0]     r_bit_cnt_q, w_bit_cnt_d;
    logic [c_TMO_W-1:0]     r_tmo_q, w_tmo_d;
    logic                   r_frame_err_q, w_frame_err_d;
    logic                   w_rise, w_bit, w_timeout, w_push, w_frame_err_set;

    // Both chains have equal depth so a data bit stays aligned with its clock edge.
    assign w_sclk_sync_d  = {r_sclk_sync_q[SYNC_STAGES-2:0],  bus.sclk};
    assign w_sdata_sync_d = {r_sdata_sync_q[SYNC_STAGES-2:0], bus.sdata};
    assign w_rise    = r_sclk_sync_q[SYNC_STAGES-1] & ~r_sclk_prev_q;
    assign w_bit     = r_sdata_sync_q[SYNC_STAGES-1];
    assign w_timeout = (r_tmo_q == c_TMO_LAST);

    always_ff @(posedge clki) begin
        if (rst) begin
            r_state_q <= RX_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            RX_IDLE:  if (w_rise) w_state_d = RX_SHIFT;
            RX_SHIFT: begin
                if (w_rise && r_bit_cnt_q == c_LAST_BIT) begin
                    w_state_d = RX_PUSH;
                end else if (!w_rise && w_timeout) begin
                    w_state_d = RX_IDLE;
                end
            end
            RX_PUSH:  w_state_d = w_rise ? RX_SHIFT : RX_IDLE;
            default:  w_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        w_push          = (r_state_q == RX_PUSH);
        w_frame_err_set = (r_state_q == RX_SHIFT) && !w_rise && w_timeout;
    end

    always_comb begin
        w_shift_d = w_rise ? {r_shift_q[DATA_W-2:0], w_bit} : r_shift_q;
        if (r_state_q == RX_SHIFT) begin
            w_bit_cnt_d = w_rise ? r_bit_cnt_q + 1'b1 : r_bit_cnt_q;
            w_tmo_d     = (w_rise || w_timeout) ? '0 : r_tmo_q + 1'b1;
        end else begin
            // A rise in IDLE or PUSH starts a new frame with its first bit taken.
            w_bit_cnt_d = w_rise ? c_CNT_W'(1) : '0;
            w_tmo_d     = '0;
        end
        if (w_frame_err_set) begin
            w_frame_err_d = 1'b1;
        end else if (bus.err_clr) begin
            w_frame_err_d = 1'b0;
        end else begin
            w_frame_err_d = r_frame_err_q;
        end
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            r_sclk_sync_q  <= '0;
            r_sdata_sync_q <= '0;
            r_sclk_prev_q  <= 1'b0;
            r_shift_q      <= '0;
            r_bit_cnt_q    <= '0;
            r_tmo_q        <= '0;
            r_frame_err_q  <= 1'b0;
        end else begin
            r_sclk_sync_q  <= w_sclk_sync_d;
            r_sdata_sync_q <= w_sdata_sync_d;
            r_sclk_prev_q  <= r_sclk_sync_q[SYNC_STAGES-1];
            r_shift_q      <= w_shift_d;
            r_bit_cnt_q    <= w_bit_cnt_d;
            r_tmo_q        <= w_tmo_d;
            r_frame_err_q  <= w_frame_err_d;
        end
    end

    assign bus.frame_err = r_frame_err_q;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clki),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (r_shift_q),
        .i_rd_en   (bus.rd_en),
        .i_err_clr (bus.err_clr),
        .o_rd_data (bus.rd_data),
        .o_empty   (bus.empty),
        .o_full    (bus.full),
        .o_overrun (bus.overrun)
    );
endmodule
`default_nettype wire

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- Receiving end of the two-wire LED serial link (sclk/sdata) driven by the serial output block.
- Oversamples the link on the system clock, deserialises frames MSB-first and buffers them in a small FIFO.
- Presents received bytes on a first-word-fall-through read port for a CPU-side peripheral or debug board.
- Detects resync/idle gaps, partial frames and buffer overrun.

Parameters:
- DATA_W, 8, bits per frame.
- FIFO_DEPTH, 4, frames buffered; power of two, minimum 2.
- TIMEOUT, 1024, clki cycles without an sclk rising edge that end a frame in progress.
- SYNC_STAGES, 2, flip-flop stages on sclk and sdata; minimum 2.

Ports:
- clki  in  1  system clock; every flop in the block runs on it.
- rst  in  1  reset; synchronous, active-high.
- sclk  in  1  link clock, asynchronous to clki, idle low; data valid at its rising edge.
- sdata  in  1  link data, asynchronous to clki.
- rd_en  in  1  pop the FIFO head this cycle.
- err_clr  in  1  clear the sticky error flags.
- rd_data  out  DATA_W  FIFO head; meaningful only while empty=0.
- empty  out  1  FIFO holds no frames.
- full  out  1  FIFO holds FIFO_DEPTH frames.
- overrun  out  1  sticky: a completed frame was dropped because the FIFO was full.
- frame_err  out  1  sticky: a partial frame was discarded on timeout.

Behaviour:
- Reset (synchronous, active-high, effective at the next clki edge, including mid-frame):
  - FIFO emptied; outputs empty=1, full=0, overrun=0, frame_err=0, rd_data=0.
  - Synchronisers loaded with 0; bit counter 0; timeout counter 0; FSM to IDLE.
- Synchronisation: sclk and sdata pass through identical SYNC_STAGES chains, so they stay aligned.
- Edge detect: rise = sclk_sync & ~sclk_prev. Sample sdata_sync in the same cycle.
- FSM:
  - IDLE:
    - On rise: shift_reg <= {shift_reg[DATA_W-2:0], bit}, bit_cnt <= 1, go to SHIFT.
    - The timeout counter does not run in IDLE.
  - SHIFT:
    - Each rise shifts in one bit (MSB first), increments bit_cnt and clears the timeout counter.
    - On the rise that makes bit_cnt reach DATA_W: go to PUSH.
    - If the timeout counter reaches TIMEOUT-1 without a rise: discard the partial frame, set frame_err, go to IDLE.
  - PUSH (exactly one cycle):
    - Write the assembled byte to the FIFO, or drop it and set overrun, following the rules below.
    - Go to IDLE. A rise seen in this cycle is handled as IDLE would handle it (go directly to SHIFT with bit_cnt=1), so back-to-back frames lose no bits.
- Latency: last-bit rise cycle, then PUSH cycle; empty drops and rd_data becomes valid on the clki edge that ends PUSH. Total of 2 clki cycles after the synchronised rise.
- FIFO (first-word-fall-through):
  - rd_data always shows the head.
  - rd_en while empty=0 pops the head; rd_en while empty is ignored.
  - Push and pop in the same cycle: both take effect, including when full (the pop frees the slot). Count is unchanged.
  - Push while full with no pop: byte dropped, overrun <= 1, FIFO contents unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is one bit wider to separate full from empty.
- Sticky flags:
  - err_clr clears overrun and frame_err.
  - If a set event and err_clr occur in the same cycle, the set wins.
- Link timing requirement: sclk high and low phases must each be at least SYNC_STAGES+1 clki cycles. Faster links are unsupported; no detection is required.

Decomposition:
- Shared package serial_pkg holds:
  - localparams SERIAL_DATA_W=8 and SERIAL_TIMEOUT_DEFAULT=1024;
  - rx FSM state encodings RX_IDLE, RX_SHIFT, RX_PUSH (2-bit).
- The serial output block imports serial_pkg as well, so frame width stays consistent across both ends.
- One sub-module: sync_fifo (parameters DATA_W, DEPTH), containing the push/pop/full/empty/overrun logic. serial_rx instantiates it.

Test Plan:
- Reset then send 0xA5, with sclk at 8 clki per half-period: exactly one entry appears; rd_data=0xA5; empty falls 2 clki after the synchronised 8th rise; both flags stay 0.
- Send 0x01, 0x80, 0xFF, 0x3C back-to-back with no gap: full=1 and 4 entries. Pop four times; expect 0x01, 0x80, 0xFF, 0x3C in order, then empty=1.
- With the FIFO full, send 0x55 without popping: overrun=1, contents unchanged. Then assert err_clr: overrun=0.
- With the FIFO full, send 0x77 and hold rd_en high during the PUSH cycle: 0x01 is popped and 0x77 is accepted at the tail; overrun stays 0; full stays 1.
- Send 5 bits, then idle 1100 clki; then send 0xC3: frame_err=1, no partial byte is stored, and the next entry is 0xC3.
- Assert rst after 4 bits of a frame, then send 0x5A: all outputs return to reset values, and the next entry is 0x5A.
